// File: rtl/vga_timing_ctrl.sv
// Raster sequencer for the VGA output path: steps horizontal/vertical phase
// machines on each pixel_en strobe and decodes sync, data-enable and coordinates.
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pixel_en,
  input  logic             run,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] px_x,
  output logic [CNT_W-1:0] px_y,
  output logic             line_start,
  output logic             frame_start,
  output logic [1:0]       h_phase,
  output logic [1:0]       v_phase
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last count of each phase; the phase advances when leaving that count.
  localparam logic [CNT_W-1:0] H_END_A = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_END_F = CNT_W'(H_ACTIVE + H_FP - 1);
  localparam logic [CNT_W-1:0] H_END_S = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] H_END_B = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_END_A = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_END_F = CNT_W'(V_ACTIVE + V_FP - 1);
  localparam logic [CNT_W-1:0] V_END_S = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_END_B = CNT_W'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  phase_t           h_state, h_state_nxt;
  phase_t           v_state, v_state_nxt;
  logic [CNT_W-1:0] h_cnt, h_cnt_nxt;
  logic [CNT_W-1:0] v_cnt, v_cnt_nxt;
  logic             run_q;
  logic             step;
  logic             h_wrap;

  // pixel_en is a strobe with no back-pressure: every pulse seen while
  // run_q=1 is consumed on that edge and advances the raster by one slot.
  assign step   = run_q & pixel_en;
  assign h_wrap = step & (h_cnt == H_END_B);

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q   <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      h_state <= PH_ACTIVE;
      v_state <= PH_ACTIVE;
    end else begin
      run_q <= run;
      if (!run_q) begin
        h_cnt   <= '0;
        v_cnt   <= '0;
        h_state <= PH_ACTIVE;
        v_state <= PH_ACTIVE;
      end else begin
        h_cnt   <= h_cnt_nxt;
        v_cnt   <= v_cnt_nxt;
        h_state <= h_state_nxt;
        v_state <= v_state_nxt;
      end
    end
  end

  always_comb begin
    h_cnt_nxt   = h_cnt;
    v_cnt_nxt   = v_cnt;
    h_state_nxt = h_state;
    v_state_nxt = v_state;
    if (step) begin
      h_cnt_nxt = h_wrap ? '0 : h_cnt + 1'b1;
      case (h_state)
        PH_ACTIVE: if (h_cnt == H_END_A) h_state_nxt = PH_FRONT;
        PH_FRONT:  if (h_cnt == H_END_F) h_state_nxt = PH_SYNC;
        PH_SYNC:   if (h_cnt == H_END_S) h_state_nxt = PH_BACK;
        PH_BACK:   if (h_cnt == H_END_B) h_state_nxt = PH_ACTIVE;
        default:   h_state_nxt = PH_ACTIVE;
      endcase
    end
    // The vertical axis only moves on the horizontal wrap edge.
    if (h_wrap) begin
      v_cnt_nxt = (v_cnt == V_END_B) ? '0 : v_cnt + 1'b1;
      case (v_state)
        PH_ACTIVE: if (v_cnt == V_END_A) v_state_nxt = PH_FRONT;
        PH_FRONT:  if (v_cnt == V_END_F) v_state_nxt = PH_SYNC;
        PH_SYNC:   if (v_cnt == V_END_S) v_state_nxt = PH_BACK;
        PH_BACK:   if (v_cnt == V_END_B) v_state_nxt = PH_ACTIVE;
        default:   v_state_nxt = PH_ACTIVE;
      endcase
    end
  end

  // Syncs are gated by run_q so a stale SYNC phase never shows while idle.
  assign hsync       = (run_q && h_state == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign vsync       = (run_q && v_state == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign de          = run_q & (h_state == PH_ACTIVE) & (v_state == PH_ACTIVE);
  assign px_x        = h_cnt;
  assign px_y        = v_cnt;
  assign line_start  = step & (h_cnt == '0);
  assign frame_start = line_start & (v_cnt == '0);
  assign h_phase     = h_state;
  assign v_phase     = v_state;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl using a reduced 16x8 raster so whole
// frames fit in a short run; expectations come from coordinate ranges.
module tb_vga_timing_ctrl;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int H_TOTAL  = 16;
  localparam int V_TOTAL  = 8;
  localparam int CNT_W    = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pixel_en = 1'b0;
  logic             run = 1'b0;
  logic             hsync, vsync, de, line_start, frame_start;
  logic [CNT_W-1:0] px_x, px_y;
  logic [1:0]       h_phase, v_phase;

  vga_timing_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(1'b0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .run(run),
    .hsync(hsync), .vsync(vsync), .de(de), .px_x(px_x), .px_y(px_y),
    .line_start(line_start), .frame_start(frame_start),
    .h_phase(h_phase), .v_phase(v_phase)
  );

  // clock / reset
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   ex = 0;
  int   ey = 0;
  logic erq = 1'b0;
  int   pss = -1;
  int   de_cnt = 0;
  int   ls_cnt = 0;
  logic last_fs = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (x=%0d y=%0d)", tag, obs, exp, ex, ey);
    end
  endtask

  // One clock: drive pixel_en, check combinational pulses, step the model,
  // then check the registered outputs after the edge.
  task automatic tick(input logic pe);
    logic ls_e;
    logic exp_de, exp_hs, exp_vs;
    @(negedge clk);
    pixel_en = pe;
    #1;
    ls_e = erq && pe && (ex == 0);
    check("line_start", 32'(line_start), 32'(ls_e));
    check("frame_start", 32'(frame_start), 32'(ls_e && (ey == 0)));
    last_fs = frame_start;
    if (erq && pe) begin
      if (frame_start) begin
        if (pss >= 0) begin
          check("fs_period", 32'(pss), 32'(H_TOTAL * V_TOTAL));
          check("de_per_frame", 32'(de_cnt), 32'(H_ACTIVE * V_ACTIVE));
          check("ls_per_frame", 32'(ls_cnt), 32'(V_TOTAL));
        end
        pss = 0;
        de_cnt = 0;
        ls_cnt = 0;
      end
      if (pss >= 0) begin
        pss++;
        de_cnt += int'(de);
        ls_cnt += int'(line_start);
      end
    end
    @(posedge clk);
    if (reset) begin
      ex = 0; ey = 0; erq = 1'b0; pss = -1;
    end else begin
      if (!erq) begin
        ex = 0; ey = 0; pss = -1;
      end else if (pe) begin
        if (ex == H_TOTAL - 1) begin
          ex = 0;
          ey = (ey == V_TOTAL - 1) ? 0 : ey + 1;
        end else begin
          ex++;
        end
      end
      erq = run;
    end
    #1;
    exp_de = erq && (ex < H_ACTIVE) && (ey < V_ACTIVE);
    exp_hs = !(erq && (ex >= H_ACTIVE + H_FP) && (ex < H_ACTIVE + H_FP + H_SYNC));
    exp_vs = !(erq && (ey >= V_ACTIVE + V_FP) && (ey < V_ACTIVE + V_FP + V_SYNC));
    check("px_x", 32'(px_x), 32'(ex));
    check("px_y", 32'(px_y), 32'(ey));
    check("de", 32'(de), 32'(exp_de));
    check("hsync", 32'(hsync), 32'(exp_hs));
    check("vsync", 32'(vsync), 32'(exp_vs));
  endtask

  // driver tasks
  task automatic run_regular(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0); tick(1'b0); tick(1'b0); tick(1'b1);
    end
  endtask

  task automatic run_irregular(input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = int'($urandom_range(0, 6));
      for (int g = 0; g < gap; g++) tick(1'b0);
      tick(1'b1);
    end
  endtask

  task automatic run_until(input int tx, input int ty);
    int budget;
    budget = 4 * H_TOTAL * V_TOTAL * 2;
    while (!(ex == tx && ey == ty)) begin
      if (budget == 0) begin
        check("run_until_timeout", 32'd1, 32'd0);
        return;
      end
      budget--;
      tick(1'b0); tick(1'b1);
    end
  endtask

  task automatic first_pulse_fs(input string tag);
    logic consumed;
    consumed = 1'b0;
    for (int i = 0; i < 20 && !consumed; i++) begin
      consumed = erq;
      tick(1'b1);
    end
    check({tag, "_consumed"}, 32'(consumed), 32'd1);
    check(tag, 32'(last_fs), 32'd1);
  endtask

  initial begin
    // reset held 3 clocks with pixel_en toggling
    reset = 1'b1; run = 1'b0;
    tick(1'b1); tick(1'b0); tick(1'b1);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick(i[0]);
    check("idle_px_x", 32'(px_x), 32'd0);

    // regular pixel_en every 4th clk, three frames
    run = 1'b1;
    run_regular(3 * H_TOTAL * V_TOTAL + 4);

    // irregular pulse spacing, two frames
    run_irregular(2 * H_TOTAL * V_TOTAL);

    // reset in the middle of an hsync pulse
    run_until(11, 2);
    check("pre_rst_hsync", 32'(hsync), 32'd0);
    reset = 1'b1;
    tick(1'b1);
    check("mid_rst_hsync", 32'(hsync), 32'd1);
    check("mid_rst_px_x", 32'(px_x), 32'd0);
    check("mid_rst_de", 32'(de), 32'd0);
    reset = 1'b0;
    first_pulse_fs("rst_restart_fs");
    run_regular(H_TOTAL * V_TOTAL + 2);

    // run dropped mid-frame, re-raised 20 clks later
    run_until(5, 1);
    run = 1'b0;
    for (int i = 0; i < 20; i++) tick(i[0]);
    check("drop_px_x", 32'(px_x), 32'd0);
    check("drop_px_y", 32'(px_y), 32'd0);
    check("drop_de", 32'(de), 32'd0);
    run = 1'b1;
    first_pulse_fs("run_restart_fs");
    run_regular(H_TOTAL * V_TOTAL + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
